// File: rtl/coordinate_uart_tx_pkg.sv
// coordinate_uart_tx_pkg: packet header bytes, FSM encodings and the packet byte selector.
package coordinate_uart_tx_pkg;
  localparam logic [7:0] HDR_MATCH = 8'h4D;
  localparam logic [7:0] HDR_NO_MATCH = 8'h4E;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} top_state_t;
  typedef enum logic [1:0] {B_IDLE, START, DATA, STOP} byte_state_t;
  function automatic logic [7:0] pkt_byte(input logic match, input logic [2:0] idx,
                                          input logic [9:0] x, input logic [8:0] y);
    return !match ? HDR_NO_MATCH :
           idx == 3'd0 ? HDR_MATCH :
           idx == 3'd1 ? {6'b0, x[9:8]} :
           idx == 3'd2 ? x[7:0] :
           idx == 3'd3 ? {7'b0, y[8]} : y[7:0];
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serializer, LSB first; done pulses in the last cycle of the stop bit.
module uart_byte_tx
  import coordinate_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  byte_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic tick;
  always_comb begin
    tick = cnt == LAST;
    state_nx = state == B_IDLE ? (load ? START : B_IDLE) :
               !tick ? state :
               state == START ? DATA :
               state == DATA ? (bit_idx == 3'd7 ? STOP : DATA) : B_IDLE;
    tx = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    done = state == STOP && tick;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= B_IDLE;
    else state <= state_nx;
  // cnt sits at 0 while idle so every bit starts a full period
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else begin
      cnt <= (state == B_IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == B_IDLE && load) begin
        shreg <= data;
        bit_idx <= '0;
      end else if (state == DATA && tick) begin
        shreg <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
endmodule

// File: rtl/coordinate_uart_tx.sv
// coordinate_uart_tx: sends 'M' + x/y match packet or 'N' no-match byte over UART.
// Define CHECKSUM_EN to append an XOR checksum byte to every packet.
module coordinate_uart_tx
  import coordinate_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_match,
  input  logic       send_no_match,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  output logic       tx,
  output logic       busy,
  output logic       send_complete
);
  top_state_t state, state_nx;
  logic match_q, accept, load, done;
  logic [9:0] x_q;
  logic [8:0] y_q;
  logic [2:0] byte_idx, last_idx;
  logic [7:0] data;
  always_comb begin
    accept = state == IDLE && (send_match || send_no_match);
`ifdef CHECKSUM_EN
    last_idx = match_q ? 3'd5 : 3'd1;
    data = byte_idx != last_idx ? pkt_byte(match_q, byte_idx, x_q, y_q) :
           match_q ? HDR_MATCH ^ {6'b0, x_q[9:8]} ^ x_q[7:0] ^ {7'b0, y_q[8]} ^ y_q[7:0] :
           HDR_NO_MATCH;
`else
    last_idx = match_q ? 3'd4 : 3'd0;
    data = pkt_byte(match_q, byte_idx, x_q, y_q);
`endif
    state_nx = state == IDLE ? (accept ? LOAD : IDLE) :
               state == LOAD ? SEND :
               state == SEND ? (!done ? SEND : byte_idx == last_idx ? DONE : LOAD) : IDLE;
    load = state == LOAD;
    busy = state == LOAD || state == SEND;
    send_complete = state == DONE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      match_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      match_q <= send_match;
      x_q <= x_in;
      y_q <= y_in;
      byte_idx <= '0;
    end else if (state == SEND && done) begin
      byte_idx <= byte_idx + 1'b1;
    end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clock(clock),
    .reset(reset),
    .data(data),
    .load(load),
    .tx(tx),
    .done(done)
  );
endmodule

// File: tb/tb_coordinate_uart_tx.sv
// tb_coordinate_uart_tx: directed checks of packet content and cycle timing at CLKS_PER_BIT=4.
module tb_coordinate_uart_tx;
  localparam int CPB = 4;
  localparam int LOGN = 8192;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic send_match = 1'b0;
  logic send_no_match = 1'b0;
  logic [9:0] x_in = '0;
  logic [8:0] y_in = '0;
  logic tx, busy, send_complete;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0, t1;
  logic tx_log[LOGN], busy_log[LOGN], sc_log[LOGN];
  int fn, sc_n, sc_first, busy_n;
  logic [7:0] fb[8];
  int fs[8];
  logic fstop;

  coordinate_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .send_match(send_match),
    .send_no_match(send_no_match),
    .x_in(x_in),
    .y_in(y_in),
    .tx(tx),
    .busy(busy),
    .send_complete(send_complete)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // cycle n is the one ending at the n-th posedge; sampled mid-cycle
  always @(negedge clock)
    if (cyc < LOGN) begin
      tx_log[cyc] = tx;
      busy_log[cyc] = busy;
      sc_log[cyc] = send_complete;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int base, input int span);
    int c;
    fn = 0;
    fstop = 1'b1;
    c = base;
    while (c < base + span && fn < 8 && c + CPB * 10 < LOGN) begin
      if (tx_log[c] === 1'b0) begin
        fs[fn] = c - base;
        for (int i = 0; i < 8; i++) fb[fn][i] = tx_log[c + CPB * (i + 1) + 1];
        if (tx_log[c + CPB * 9 + 1] !== 1'b1) fstop = 1'b0;
        fn++;
        c += CPB * 10;
      end else c++;
    end
  endtask

  task automatic scan(input int base, input int span);
    sc_n = 0;
    sc_first = -1;
    busy_n = 0;
    for (int c = base; c < base + span; c++) begin
      if (sc_log[c] === 1'b1) begin
        if (sc_n == 0) sc_first = c - base;
        sc_n++;
      end
      if (busy_log[c] === 1'b1) busy_n++;
    end
  endtask

  task automatic start_req(input logic m, input logic nm, input logic [9:0] x,
                           input logic [8:0] y, output int base);
    @(negedge clock);
    send_match = m;
    send_no_match = nm;
    x_in = x;
    y_in = y;
    base = cyc;
    @(negedge clock);
    send_match = 1'b0;
    send_no_match = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sc", send_complete, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    start_req(1, 0, 10'h2A5, 9'h1F0, t0);
    repeat (240) @(negedge clock);
    chk("m_busy_c0", busy_log[t0], 0);
    chk("m_busy_c1", busy_log[t0 + 1], 1);
    chk("m_tx_c1", tx_log[t0 + 1], 1);
    chk("m_tx_c2", tx_log[t0 + 2], 0);
    frames(t0, 240);
    chk("m_nbytes", fn, 5);
    chk("m_bytes", {fb[0], fb[1], fb[2], fb[3], fb[4]}, 40'h4D02A501F0);
    chk("m_start0", fs[0], 2);
    chk("m_start1", fs[1], 43);
    chk("m_stop", fstop, 1);
    scan(t0, 240);
    chk("m_sc_n", sc_n, 1);
    chk("m_sc_cyc", sc_first, 206);
    chk("m_busy_n", busy_n, 205);
    chk("m_busy_done", busy_log[t0 + 206], 0);

    start_req(0, 1, 10'h0, 9'h0, t0);
    repeat (60) @(negedge clock);
    frames(t0, 60);
    chk("n_nbytes", fn, 1);
    chk("n_byte", fb[0], 8'h4E);
    chk("n_start", fs[0], 2);
    scan(t0, 60);
    chk("n_sc_n", sc_n, 1);
    chk("n_sc_cyc", sc_first, 42);
    chk("n_busy_n", busy_n, 41);

    start_req(1, 1, 10'h3FF, 9'h1FF, t0);
    repeat (240) @(negedge clock);
    frames(t0, 240);
    chk("both_nbytes", fn, 5);
    chk("both_bytes", {fb[0], fb[1], fb[2], fb[3], fb[4]}, 40'h4D03FF01FF);
    scan(t0, 240);
    chk("both_sc_n", sc_n, 1);

    start_req(1, 0, 10'h2A5, 9'h1F0, t0);
    repeat (58) @(negedge clock);
    send_match = 1'b1;
    send_no_match = 1'b1;
    x_in = 10'h155;
    y_in = 9'h0AA;
    @(negedge clock);
    send_match = 1'b0;
    send_no_match = 1'b0;
    repeat (190) @(negedge clock);
    frames(t0, 245);
    chk("busyreq_nbytes", fn, 5);
    chk("busyreq_bytes", {fb[0], fb[1], fb[2], fb[3], fb[4]}, 40'h4D02A501F0);
    scan(t0, 245);
    chk("busyreq_sc_n", sc_n, 1);
    chk("busyreq_sc_cyc", sc_first, 206);

    start_req(1, 0, 10'h2A5, 9'h1F0, t0);
    repeat (99) @(negedge clock);
    chk("abort_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sc", send_complete, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    scan(t0, cyc - t0);
    chk("abort_sc_n", sc_n, 0);
    start_req(0, 1, 10'h0, 9'h0, t1);
    repeat (60) @(negedge clock);
    frames(t1, 60);
    chk("post_nbytes", fn, 1);
    chk("post_byte", fb[0], 8'h4E);
    chk("post_stop", fstop, 1);
    scan(t1, 60);
    chk("post_sc_cyc", sc_first, 42);

    @(negedge clock);
    send_match = 1'b1;
    x_in = 10'h1C3;
    y_in = 9'h105;
    t0 = cyc;
    @(negedge clock);
    send_match = 1'b0;
    x_in = 10'h3FF;
    y_in = 9'h000;
    repeat (240) @(negedge clock);
    frames(t0, 240);
    chk("cap_nbytes", fn, 5);
    chk("cap_bytes", {fb[0], fb[1], fb[2], fb[3], fb[4]}, 40'h4D01C30105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
